alu_seq: RTL and testbench
==========================

# alu_seq

Parametrised sequential ALU: the registered, handshaked successor to the 16-bit combinational ALU. It adds a multi-cycle unsigned multiply and status flags (carry, zero, overflow, negative), with operand width set by parameter. It sits behind the datapath's operand registers: the controller issues one operation per `start` and samples the results on `done`.

## Interface
- `WIDTH`, 16: operand/result width; legal range 2..64.
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst_n` input 1: synchronous, active-low reset, sampled on the rising edge of `clk`.
- `start` input 1: issue request; accepted only when `ready`=1.
- `op` input 3: operation select.
  - 0 = NOT A
  - 1 = A XOR B
  - 2 = A+B+Cin
  - 3 = A−B
  - 4 = A×B unsigned
  - 5–7 behave as op 0
- `A`, `B` input WIDTH: operands, sampled on the accepting edge only.
- `Cin` input 1: carry-in, used by op 2 only.
- `ready` output 1: block idle, can accept `start`.
- `done` output 1: one-cycle pulse; results valid from this cycle.
- `S` output WIDTH: result, low half of the product for op 4.
- `S_hi` output WIDTH: high half of the product for op 4; 0 for all other ops.
- `Cout`, `Z`, `V`, `N` output 1 each: carry, zero, signed overflow, negative flags.

## Operation
- FSM states: IDLE, MUL.
- IDLE, `start`=1, op≠4:
  - Compute result and flags, register them on the same edge.
  - Pulse `done` next cycle.
  - Stay in IDLE with `ready` held at 1, so back-to-back issue every cycle is legal.
- IDLE, `start`=1, op=4:
  - Latch A, B; clear the accumulator and the counter (width clog2(WIDTH)+1).
  - Go to MUL; `ready`=0.
- MUL:
  - Shift-add one bit of B per cycle, LSB first, over a 2·WIDTH accumulator.
  - After WIDTH iterations: write `S_hi`:`S`, write flags, pulse `done`, raise `ready`, return to IDLE.
- `start` while `ready`=0 is ignored, not queued; A/B changes during MUL have no effect.
- Flag rules:
  - NOT/XOR: Cout=0, V=0.
  - ADD: Cout = carry out of bit WIDTH−1; V = (A[msb]==B[msb]) && (S[msb]≠A[msb]).
  - SUB: computed as A+~B+1 with Cin ignored. Cout=1 means no borrow (A≥B unsigned). V = (A[msb]≠B[msb]) && (S[msb]≠A[msb]).
  - MUL: Cout=0; V=1 iff `S_hi`≠0; Z and N over the full 2·WIDTH product (N = `S_hi`[msb]).
  - All other ops: Z = (S==0), N = S[msb].
- Outputs hold their last values between operations. `done` is the only pulsed output.

## Timing
- Reset (`rst_n`=0 at an edge):
  - State to IDLE; `ready`=1, `done`=0.
  - `S`, `S_hi`, `Cout`, `Z`, `V`, `N` all 0. `Z` resets to 0, not 1.
- Reset overrides `start` on the same edge.
- Reset during MUL aborts the operation; no `done` is produced.
- Single-cycle ops: `start` sampled at edge k; results and `done`=1 are visible after edge k, i.e. 1-cycle latency.
- MUL: `start` sampled at edge k; iterations occur on edges k+1..k+WIDTH.
  - Results and `done` are visible after edge k+WIDTH, i.e. WIDTH+1 edges from acceptance.
  - `ready`=0 for cycles k+1..k+WIDTH.
  - `ready`=1 in the `done` cycle, so a new `start` is accepted on the edge that ends the `done` cycle.
- No combinational path from inputs to outputs; all outputs come from registers.

## Test plan
- ADD overflow, WIDTH=16: A=0x7FFF, B=0x0001, Cin=0, op=2 → next cycle S=0x8000, V=1, N=1, Cout=0, Z=0, `done` pulses once.
- SUB borrow: A=0x0005, B=0x0007, op=3 → S=0xFFFE, Cout=0, N=1, V=0. Then A=B=0x1234 → S=0, Z=1, Cout=1.
- MUL max: A=B=0xFFFF, op=4 → `ready` low for 16 cycles; `done` after edge k+16; S_hi=0xFFFE, S=0x0001, V=1, N=1, Z=0.
- Busy rejection: issue MUL 3×5, then assert `start` with op=2 during MUL → ignored. Single `done` with S=0x000F, S_hi=0; ADD never executes.
- Reset mid-MUL: drop `rst_n` at iteration 8 → all outputs 0, `ready`=1, no `done`. A fresh XOR 0xAAAA^0x5555 → S=0xFFFF, N=1.
- WIDTH=8 instance, back-to-back ops: NOT 0x0F (→0xF0), XOR 0xFF^0x0F (→0xF0), MUL 0x10×0x10 (→S_hi=0x01, S=0x00, V=1, latency 9 edges). `done` pulses on consecutive cycles for the first two.

Source files
------------

// File: rtl/alu_seq.sv
// rtl/alu_seq.sv - registered handshaked ALU with multi-cycle shift-add unsigned multiply
module alu_seq #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    output logic             ready,
    output logic             done,
    output logic [WIDTH-1:0] S,
    output logic [WIDTH-1:0] S_hi,
    output logic             Cout,
    output logic             Z,
    output logic             V,
    output logic             N
);

    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic {IDLE, MUL} state_t;

    state_t               state;
    logic [2*WIDTH-1:0]   acc;
    logic [2*WIDTH-1:0]   mcand;
    logic [2*WIDTH-1:0]   acc_nxt;
    logic [WIDTH-1:0]     mplier;
    logic [CW-1:0]        cnt;

    logic [WIDTH:0]       sum;
    logic [WIDTH-1:0]     alu_s;
    logic                 alu_c;
    logic                 alu_v;

    always_comb begin
        sum   = '0;
        alu_s = '0;
        alu_c = 1'b0;
        alu_v = 1'b0;
        case (op)
            3'd1: alu_s = A ^ B;
            3'd2: begin
                sum   = {1'b0, A} + {1'b0, B} + {{WIDTH{1'b0}}, Cin};
                alu_s = sum[WIDTH-1:0];
                alu_c = sum[WIDTH];
                alu_v = (A[WIDTH-1] == B[WIDTH-1]) && (alu_s[WIDTH-1] != A[WIDTH-1]);
            end
            3'd3: begin
                // Subtract as A + ~B + 1 so carry-out reads as "no borrow".
                sum   = {1'b0, A} + {1'b0, ~B} + (WIDTH+1)'(1);
                alu_s = sum[WIDTH-1:0];
                alu_c = sum[WIDTH];
                alu_v = (A[WIDTH-1] != B[WIDTH-1]) && (alu_s[WIDTH-1] != A[WIDTH-1]);
            end
            default: alu_s = ~A;
        endcase
    end

    assign acc_nxt = mplier[0] ? (acc + mcand) : acc;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= IDLE;
            ready  <= 1'b1;
            done   <= 1'b0;
            S      <= '0;
            S_hi   <= '0;
            Cout   <= 1'b0;
            Z      <= 1'b0;
            V      <= 1'b0;
            N      <= 1'b0;
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
            cnt    <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        if (op == 3'd4) begin
                            mcand  <= {{WIDTH{1'b0}}, A};
                            mplier <= B;
                            acc    <= '0;
                            cnt    <= '0;
                            ready  <= 1'b0;
                            state  <= MUL;
                        end else begin
                            S    <= alu_s;
                            S_hi <= '0;
                            Cout <= alu_c;
                            V    <= alu_v;
                            Z    <= (alu_s == '0);
                            N    <= alu_s[WIDTH-1];
                            done <= 1'b1;
                        end
                    end
                end
                MUL: begin
                    acc    <= acc_nxt;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    cnt    <= cnt + CW'(1);
                    // Last iteration publishes the freshly accumulated product directly.
                    if (cnt == LAST) begin
                        S     <= acc_nxt[WIDTH-1:0];
                        S_hi  <= acc_nxt[2*WIDTH-1:WIDTH];
                        Cout  <= 1'b0;
                        V     <= |acc_nxt[2*WIDTH-1:WIDTH];
                        Z     <= (acc_nxt == '0);
                        N     <= acc_nxt[2*WIDTH-1];
                        done  <= 1'b1;
                        ready <= 1'b1;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// tb/tb_alu_seq.sv - randomized and directed bench for alu_seq against an arithmetic reference model
module tb_alu_seq;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, start, cin;
    logic [2:0]  op;
    logic [15:0] a, b;
    logic        ready, done, cout, z, v, n;
    logic [15:0] s, s_hi;

    logic        start8, cin8;
    logic [2:0]  op8;
    logic [7:0]  a8, b8;
    logic        ready8, done8, cout8, z8, v8, n8;
    logic [7:0]  s8, s_hi8;

    int checks = 0;
    int errors = 0;

    alu_seq #(.WIDTH(16)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .op(op), .A(a), .B(b), .Cin(cin),
        .ready(ready), .done(done), .S(s), .S_hi(s_hi), .Cout(cout), .Z(z), .V(v), .N(n)
    );

    alu_seq #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .op(op8), .A(a8), .B(b8), .Cin(cin8),
        .ready(ready8), .done(done8), .S(s8), .S_hi(s_hi8), .Cout(cout8), .Z(z8), .V(v8), .N(n8)
    );

    typedef struct packed {
        logic [63:0] s;
        logic [63:0] s_hi;
        logic        cout;
        logic        z;
        logic        v;
        logic        n;
    } res_t;

    function automatic longint sval(int w, logic [63:0] x);
        longint u;
        u = longint'(x & ((64'd1 << w) - 64'd1));
        return x[w-1] ? (u - (longint'(1) <<< w)) : u;
    endfunction

    // Reference: plain integer arithmetic, signed overflow judged by range.
    function automatic res_t model(int w, logic [2:0] o, logic [63:0] ai, logic [63:0] bi, logic ci);
        res_t         r;
        logic [127:0] p;
        logic [63:0]  mask, am, bm;
        longint       t, lim;
        r    = '0;
        mask = (64'd1 << w) - 64'd1;
        am   = ai & mask;
        bm   = bi & mask;
        lim  = longint'(1) <<< (w - 1);
        case (o)
            3'd1: r.s = am ^ bm;
            3'd2: begin
                p      = 128'(am) + 128'(bm) + 128'(ci);
                r.s    = p[63:0] & mask;
                r.cout = p[w];
                t      = sval(w, am) + sval(w, bm) + longint'(ci);
                r.v    = (t >= lim) || (t < -lim);
            end
            3'd3: begin
                r.s    = (am - bm) & mask;
                r.cout = (am >= bm);
                t      = sval(w, am) - sval(w, bm);
                r.v    = (t >= lim) || (t < -lim);
            end
            3'd4: begin
                p      = 128'(am) * 128'(bm);
                r.s    = p[63:0] & mask;
                r.s_hi = 64'(p >> w) & mask;
                r.v    = (r.s_hi != 64'd0);
                r.z    = (p == 128'd0);
                r.n    = p[2*w-1];
            end
            default: r.s = ~am & mask;
        endcase
        if (o != 3'd4) begin
            r.z = (r.s == 64'd0);
            r.n = r.s[w-1];
        end
        return r;
    endfunction

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b1; op = 3'd2; a = 16'h0001; b = 16'h0001;
        start8 = 1'b1; op8 = 3'd1;
        @(posedge clk); @(posedge clk); @(negedge clk);
        checks++;
        if ({ready, done, s, s_hi, cout, z, v, n} !== {1'b1, 1'b0, 32'h0, 4'h0}) begin
            errors++;
            $display("FAIL reset16 got %h expected %h", {ready, done, s, s_hi, cout, z, v, n}, {1'b1, 1'b0, 32'h0, 4'h0});
        end
        checks++;
        if ({ready8, done8, s8, s_hi8, cout8, z8, v8, n8} !== {1'b1, 1'b0, 16'h0, 4'h0}) begin
            errors++;
            $display("FAIL reset8 got %h expected %h", {ready8, done8, s8, s_hi8, cout8, z8, v8, n8}, {1'b1, 1'b0, 16'h0, 4'h0});
        end
        start = 1'b0; start8 = 1'b0; rst_n = 1'b1;
        @(posedge clk); @(negedge clk);
    endtask

    task automatic test_add_sub();
        logic [2:0]  ops [3] = '{3'd2, 3'd3, 3'd3};
        logic [15:0] as  [3] = '{16'h7FFF, 16'h0005, 16'h1234};
        logic [15:0] bs  [3] = '{16'h0001, 16'h0007, 16'h1234};
        logic        cs  [3] = '{1'b0, 1'b0, 1'b1};
        logic [15:0] spec_s [3] = '{16'h8000, 16'hFFFE, 16'h0000};
        logic [3:0]  spec_f [3] = '{4'b0011, 4'b0001, 4'b1100};
        res_t r;
        for (int i = 0; i < 3; i++) begin
            op = ops[i]; a = as[i]; b = bs[i]; cin = cs[i]; start = 1'b1;
            r = model(16, ops[i], 64'(as[i]), 64'(bs[i]), cs[i]);
            @(posedge clk); @(negedge clk);
            start = 1'b0;
            checks++;
            if ({done, s_hi, s, cout, z, v, n} !== {1'b1, r.s_hi[15:0], r.s[15:0], r.cout, r.z, r.v, r.n}) begin
                errors++;
                $display("FAIL addsub_model[%0d] got %h expected %h", i, {done, s_hi, s, cout, z, v, n},
                         {1'b1, r.s_hi[15:0], r.s[15:0], r.cout, r.z, r.v, r.n});
            end
            checks++;
            if ({s, cout, z, v, n} !== {spec_s[i], spec_f[i]}) begin
                errors++;
                $display("FAIL addsub_const[%0d] got %h expected %h", i, {s, cout, z, v, n}, {spec_s[i], spec_f[i]});
            end
            @(posedge clk); @(negedge clk);
            checks++;
            if ({done, s} !== {1'b0, spec_s[i]}) begin
                errors++;
                $display("FAIL addsub_hold[%0d] got %h expected %h", i, {done, s}, {1'b0, spec_s[i]});
            end
        end
    endtask

    task automatic test_back_to_back();
        res_t       r;
        logic [2:0] o;
        for (int i = 0; i < 40; i++) begin
            o = 3'($urandom_range(0, 7));
            if (o == 3'd4) o = 3'd1;
            op = o; a = 16'($urandom); b = 16'($urandom); cin = 1'($urandom);
            if (i == 5) b = a;
            start = 1'b1;
            r = model(16, o, 64'(a), 64'(b), cin);
            @(posedge clk); @(negedge clk);
            checks++;
            if ({done, ready, s_hi, s, cout, z, v, n} !== {2'b11, r.s_hi[15:0], r.s[15:0], r.cout, r.z, r.v, r.n}) begin
                errors++;
                $display("FAIL b2b[%0d] op=%0d got %h expected %h", i, o, {done, ready, s_hi, s, cout, z, v, n},
                         {2'b11, r.s_hi[15:0], r.s[15:0], r.cout, r.z, r.v, r.n});
            end
        end
        start = 1'b0;
        @(posedge clk); @(negedge clk);
    endtask

    task automatic test_mul();
        res_t r;
        logic bad;
        for (int t = 0; t < 8; t++) begin
            op = 3'd4; start = 1'b1;
            a = (t == 0) ? 16'hFFFF : 16'($urandom);
            b = (t == 0) ? 16'hFFFF : (t == 1) ? 16'h0000 : 16'($urandom);
            r = model(16, 3'd4, 64'(a), 64'(b), 1'b0);
            @(posedge clk); @(negedge clk);
            start = 1'b0; a = 16'($urandom); b = 16'($urandom);
            bad = 1'b0;
            for (int i = 0; i < 16; i++) begin
                if (ready !== 1'b0 || done !== 1'b0) bad = 1'b1;
                @(posedge clk); @(negedge clk);
            end
            checks++;
            if (bad) begin
                errors++;
                $display("FAIL mul_busy[%0d] got ready/done high during multiply expected low", t);
            end
            checks++;
            if ({done, ready, s_hi, s, cout, z, v, n} !== {2'b11, r.s_hi[15:0], r.s[15:0], r.cout, r.z, r.v, r.n}) begin
                errors++;
                $display("FAIL mul[%0d] got %h expected %h", t, {done, ready, s_hi, s, cout, z, v, n},
                         {2'b11, r.s_hi[15:0], r.s[15:0], r.cout, r.z, r.v, r.n});
            end
            if (t == 0) begin
                checks++;
                if ({s_hi, s, v, n, z} !== {16'hFFFE, 16'h0001, 3'b110}) begin
                    errors++;
                    $display("FAIL mul_max got %h expected %h", {s_hi, s, v, n, z}, {16'hFFFE, 16'h0001, 3'b110});
                end
            end
        end
    endtask

    task automatic test_busy_reject();
        int          dones;
        logic [31:0] seen;
        op = 3'd4; a = 16'd3; b = 16'd5; start = 1'b1;
        @(posedge clk); @(negedge clk);
        op = 3'd2; a = 16'h0101; b = 16'h0202; cin = 1'b1;
        dones = 0; seen = '0;
        for (int i = 0; i < 22; i++) begin
            if (i == 15) start = 1'b0;
            @(posedge clk); @(negedge clk);
            if (done === 1'b1) begin
                dones++;
                seen = {s_hi, s};
            end
        end
        checks++;
        if (dones != 1) begin
            errors++;
            $display("FAIL busy_done_count got %0d expected 1", dones);
        end
        checks++;
        if (seen !== 32'h0000_000F || {s_hi, s} !== 32'h0000_000F) begin
            errors++;
            $display("FAIL busy_result got %h/%h expected 0000000f", seen, {s_hi, s});
        end
    endtask

    task automatic test_reset_mid_mul();
        res_t r;
        int   dones;
        op = 3'd4; a = 16'hFFFF; b = 16'hFFFF; start = 1'b1;
        @(posedge clk); @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); @(negedge clk);
        end
        rst_n = 1'b0;
        @(posedge clk); @(negedge clk);
        rst_n = 1'b1;
        checks++;
        if ({ready, done, s, s_hi, cout, z, v, n} !== {1'b1, 1'b0, 32'h0, 4'h0}) begin
            errors++;
            $display("FAIL mid_mul_reset got %h expected %h", {ready, done, s, s_hi, cout, z, v, n}, {1'b1, 1'b0, 32'h0, 4'h0});
        end
        dones = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); @(negedge clk);
            if (done !== 1'b0) dones++;
        end
        checks++;
        if (dones != 0) begin
            errors++;
            $display("FAIL mid_mul_no_done got %0d pulses expected 0", dones);
        end
        op = 3'd1; a = 16'hAAAA; b = 16'h5555; start = 1'b1;
        r = model(16, 3'd1, 64'(a), 64'(b), 1'b0);
        @(posedge clk); @(negedge clk);
        start = 1'b0;
        checks++;
        if ({done, s, n, z} !== {1'b1, r.s[15:0], r.n, r.z} || {s, n} !== {16'hFFFF, 1'b1}) begin
            errors++;
            $display("FAIL post_reset_xor got %h expected %h", {done, s, n, z}, {1'b1, 16'hFFFF, 2'b10});
        end
    endtask

    task automatic test_width8();
        res_t       r;
        logic [2:0] ops [2] = '{3'd0, 3'd1};
        logic [7:0] as  [2] = '{8'h0F, 8'hFF};
        logic [7:0] bs  [2] = '{8'h00, 8'h0F};
        logic       bad;
        for (int i = 0; i < 2; i++) begin
            op8 = ops[i]; a8 = as[i]; b8 = bs[i]; cin8 = 1'b0; start8 = 1'b1;
            r = model(8, ops[i], 64'(as[i]), 64'(bs[i]), 1'b0);
            @(posedge clk); @(negedge clk);
            checks++;
            if ({done8, s8, s_hi8, cout8, z8, v8, n8} !== {1'b1, 8'hF0, 8'h00, r.cout, r.z, r.v, r.n} || r.s[7:0] !== 8'hF0) begin
                errors++;
                $display("FAIL w8_b2b[%0d] got %h expected %h", i, {done8, s8, s_hi8, cout8, z8, v8, n8},
                         {1'b1, r.s[7:0], 8'h00, r.cout, r.z, r.v, r.n});
            end
        end
        for (int t = 0; t < 4; t++) begin
            op8 = 3'd4; start8 = 1'b1;
            a8 = (t == 0) ? 8'h10 : 8'($urandom);
            b8 = (t == 0) ? 8'h10 : 8'($urandom);
            r = model(8, 3'd4, 64'(a8), 64'(b8), 1'b0);
            @(posedge clk); @(negedge clk);
            start8 = 1'b0;
            bad = 1'b0;
            for (int i = 0; i < 8; i++) begin
                if (ready8 !== 1'b0 || done8 !== 1'b0) bad = 1'b1;
                @(posedge clk); @(negedge clk);
            end
            checks++;
            if (bad || {done8, ready8, s_hi8, s8, cout8, z8, v8, n8} !== {2'b11, r.s_hi[7:0], r.s[7:0], r.cout, r.z, r.v, r.n}) begin
                errors++;
                $display("FAIL w8_mul[%0d] busy_err=%0d got %h expected %h", t, bad, {done8, ready8, s_hi8, s8, cout8, z8, v8, n8},
                         {2'b11, r.s_hi[7:0], r.s[7:0], r.cout, r.z, r.v, r.n});
            end
            if (t == 0) begin
                checks++;
                if ({s_hi8, s8, v8} !== {8'h01, 8'h00, 1'b1}) begin
                    errors++;
                    $display("FAIL w8_mul_const got %h expected %h", {s_hi8, s8, v8}, {8'h01, 8'h00, 1'b1});
                end
            end
        end
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; op = 3'd0; a = '0; b = '0; cin = 1'b0;
        start8 = 1'b0; op8 = 3'd0; a8 = '0; b8 = '0; cin8 = 1'b0;
        @(negedge clk);
        test_reset();
        test_add_sub();
        test_back_to_back();
        test_mul();
        test_busy_reject();
        test_reset_mid_mul();
        test_width8();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
